multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 60 ++++++
 rtl/cond_eval.sv | 34 +++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// Pure definitions: no latency, no backpressure.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic       no_write;
    } cmd_dec_t;

    // Unsupported commands run as ADD but never write the register file.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        case (cmd)
            CMD_ADD: d = '{alu_ctrl: ALU_ADD, no_write: 1'b0};
            CMD_SUB: d = '{alu_ctrl: ALU_SUB, no_write: 1'b0};
            CMD_AND: d = '{alu_ctrl: ALU_AND, no_write: 1'b0};
            CMD_ORR: d = '{alu_ctrl: ALU_ORR, no_write: 1'b0};
            CMD_CMP: d = '{alu_ctrl: ALU_SUB, no_write: 1'b1};
            default: d = '{alu_ctrl: ALU_ADD, no_write: 1'b1};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: Cond x {N,Z,C,V} -> condition true.
// Purely combinational; no backpressure.
module cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = ~(n ^ v);
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & ~(n ^ v);
            4'b1101: cond_ex = z | (n ^ v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: main FSM, command decode, condition/flag registers.
// 2-5 cycles per instruction; outputs combinational from state and registered flags; no backpressure.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:12] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic        RegWrite
);

    state_t     state_q, state_d;
    logic [3:0] flags_q;
    logic       cond_ex, cond_ex_q;
    logic       reg_w, mem_w, branch, no_write;
    cmd_dec_t   dec;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    assign dec      = decode_cmd(funct[4:1]);
    assign no_write = (op == OP_DP) & dec.no_write;

    cond_eval u_cond_eval (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // C and V only move for arithmetic ALU operations; logical ops keep them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE)
                cond_ex_q <= cond_ex;
            if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && funct[0] && cond_ex_q) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (!dec.alu_ctrl[1])
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d   = S_DECODE;
                IRWrite   = 1'b1;
                ResultSrc = RES_ALURESULT;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
            end
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
                ResultSrc = RES_ALURESULT;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
            end
            S_MEMADR: begin
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                state_d   = S_FETCH;
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                state_d = S_FETCH;
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: begin
                state_d    = S_ALUWB;
                ALUControl = dec.alu_ctrl;
            end
            S_EXECUTEI: begin
                state_d    = S_ALUWB;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec.alu_ctrl;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
                reg_w   = 1'b1;
            end
            S_BRANCH: begin
                state_d   = S_FETCH;
                ResultSrc = RES_ALURESULT;
                ALUSrcB   = SRCB_IMM;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign RegWrite = reg_w & cond_ex_q & ~no_write;
    assign MemWrite = mem_w & cond_ex_q;
    assign PCWrite  = (state_q == S_FETCH)
                    | (cond_ex_q & (branch | (reg_w & (rd == 4'hF) & ~no_write)));

    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign ImmSrc = (op == 2'b11) ? 2'b00 : op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction stream
// against an instruction-level behavioural model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:12] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, RegSrc, ImmSrc, ALUControl;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    // Observed/expected vector: {RegSrc,ImmSrc,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite}
    localparam logic [15:0] M_ADR = 16'h0400;
    localparam logic [15:0] M_RES = 16'h00C0;
    localparam logic [15:0] M_ALU = 16'h003E;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  mf;
    logic [3:0]  mf_after;
    logic [15:0] exp_v[6];
    logic [15:0] exp_m[6];
    int          n_cyc;
    int          exec_idx;
    logic [15:0] obs;

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] fn, input logic [3:0] rd);
        return {c, op, fn, 4'b0000, rd};
    endfunction

    function automatic logic [15:0] pk(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic [1:0] res, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] alu,
                                       input logic regw);
        return {4'b0000, pcw, adr, memw, irw, res, srca, srcb, alu, regw};
    endfunction

    // Conditions come in true/inverted pairs selected by cond[0].
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic model(input logic [19:0] ins, input logic [3:0] af);
        logic [3:0]  c, rd, cmd;
        logic [1:0]  op, alu;
        logic [5:0]  fn;
        logic        cex, nw, arith, dst_pc;
        logic [15:0] bm, sb;
        c = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0]; cmd = fn[4:1];
        cex = cond_holds(c, mf);
        case (cmd)
            4'b0100: begin alu = 2'b00; nw = 1'b0; arith = 1'b1; end
            4'b0010: begin alu = 2'b01; nw = 1'b0; arith = 1'b1; end
            4'b0000: begin alu = 2'b10; nw = 1'b0; arith = 1'b0; end
            4'b1100: begin alu = 2'b11; nw = 1'b0; arith = 1'b0; end
            4'b1010: begin alu = 2'b01; nw = 1'b1; arith = 1'b1; end
            default: begin alu = 2'b00; nw = 1'b1; arith = 1'b1; end
        endcase
        dst_pc = (rd == 4'hF);
        bm = (op == 2'b11) ? 16'h0FFF : 16'hFFFF;
        sb = {op == 2'b01, op == 2'b10, op, 12'h000};
        exec_idx = -1;
        exp_v[0] = pk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0);  exp_m[0] = bm;
        exp_v[1] = pk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0);  exp_m[1] = bm & ~M_ADR;
        n_cyc = 2;
        if (op == 2'b01) begin
            exp_v[2] = pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0); exp_m[2] = bm & ~M_ADR & ~M_RES;
            if (fn[0]) begin
                exp_v[3] = pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0); exp_m[3] = bm & ~M_RES & ~M_ALU;
                exp_v[4] = pk(cex && dst_pc, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, cex);
                exp_m[4] = bm & ~M_ADR & ~M_ALU;
                n_cyc = 5;
            end else begin
                exp_v[3] = pk(0, 1, cex, 0, 2'b00, 0, 2'b00, 2'b00, 0); exp_m[3] = bm & ~M_RES & ~M_ALU;
                n_cyc = 4;
            end
        end else if (op == 2'b00) begin
            exp_v[2] = pk(0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, alu, 0);
            exp_m[2] = bm & ~M_ADR & ~M_RES;
            exec_idx = 2;
            exp_v[3] = pk(cex && !nw && dst_pc, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, cex && !nw);
            exp_m[3] = bm & ~M_ADR & ~M_ALU;
            n_cyc = 4;
        end else if (op == 2'b10) begin
            exp_v[2] = pk(cex, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0); exp_m[2] = bm & ~M_ADR;
            n_cyc = 3;
        end
        for (int i = 0; i < n_cyc; i++) exp_v[i] = exp_v[i] | sb;
        mf_after = mf;
        if (op == 2'b00 && fn[0] && cex) begin
            mf_after[3:2] = af[3:2];
            if (arith) mf_after[1:0] = af[1:0];
        end
    endtask

    // One clock cycle starting #1 after a rising edge; samples outputs mid-cycle.
    task automatic cycle(input logic [3:0] af, output logic [15:0] o);
        ALUFlags = af;
        #2;
        o = {RegSrc, ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, RegWrite};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = '0; ALUFlags = '0; mf = 4'b0000;
        #3;
        obs = {RegSrc, ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite};
        n_chk++;
        if (obs !== pk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0)) begin
            n_fail++;
            $display("FAIL reset_fetch: got %h expected %h", obs, pk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0));
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [19:0] q[$];
        logic [3:0]  af;
        q = '{mk(4'hE, 2'b00, 6'b001000, 4'h1), mk(4'hE, 2'b00, 6'b101000, 4'h2),
              mk(4'hE, 2'b00, 6'b011000, 4'h3)};
        foreach (q[k]) begin
            af = 4'($urandom);
            model(q[k], af);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle((c == exec_idx) ? af : 4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL add cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_mem();
        logic [19:0] q[$];
        q = '{mk(4'hE, 2'b01, 6'b011001, 4'h4), mk(4'hE, 2'b01, 6'b011000, 4'h5),
              mk(4'hE, 2'b01, 6'b011001, 4'hF), mk(4'h1, 2'b01, 6'b011000, 4'h5)};
        foreach (q[k]) begin
            model(q[k], 4'h0);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle(4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL mem cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_branch();
        logic [19:0] q[$];
        logic [3:0]  a[$];
        q = '{mk(4'hE, 2'b00, 6'b000101, 4'h1), mk(4'h0, 2'b10, 6'b000000, 4'h0),
              mk(4'h1, 2'b10, 6'b000000, 4'h0), mk(4'hE, 2'b00, 6'b000101, 4'h1),
              mk(4'h0, 2'b10, 6'b000000, 4'h0), mk(4'h1, 2'b10, 6'b000000, 4'h0)};
        a = '{4'b0100, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0};
        foreach (q[k]) begin
            model(q[k], a[k]);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle((c == exec_idx) ? a[k] : 4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL branch cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_cmp();
        logic [19:0] q[$];
        logic [3:0]  a[$];
        q = '{mk(4'hE, 2'b00, 6'b010101, 4'h0), mk(4'h4, 2'b10, 6'b0, 4'h0), mk(4'h6, 2'b10, 6'b0, 4'h0),
              mk(4'hF, 2'b00, 6'b010101, 4'h0), mk(4'h4, 2'b10, 6'b0, 4'h0), mk(4'h0, 2'b10, 6'b0, 4'h0),
              mk(4'hE, 2'b00, 6'b011001, 4'h2), mk(4'h2, 2'b10, 6'b0, 4'h0), mk(4'h1, 2'b10, 6'b0, 4'h0)};
        a = '{4'b1001, 4'h0, 4'h0, 4'b0110, 4'h0, 4'h0, 4'b0110, 4'h0, 4'h0};
        foreach (q[k]) begin
            model(q[k], a[k]);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle((c == exec_idx) ? a[k] : 4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL cmp cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_pc_dest();
        logic [19:0] q[$];
        q = '{mk(4'hE, 2'b00, 6'b001000, 4'hF), mk(4'hE, 2'b00, 6'b010101, 4'hF),
              mk(4'hF, 2'b00, 6'b001000, 4'hF)};
        foreach (q[k]) begin
            model(q[k], 4'h0);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle(4'h0, obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL pc_dest cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] q[$];
        logic [19:0] ldr;
        logic [15:0] fv;
        ldr = mk(4'hE, 2'b01, 6'b011001, 4'h3);
        // Set Z first so that the flag clear by reset becomes visible to BEQ/BNE.
        model(mk(4'hE, 2'b00, 6'b000101, 4'h1), 4'b0100);
        Instr = mk(4'hE, 2'b00, 6'b000101, 4'h1);
        for (int c = 0; c < n_cyc; c++) cycle((c == exec_idx) ? 4'b0100 : 4'h0, obs);
        mf = mf_after;
        model(ldr, 4'h0);
        Instr = ldr;
        for (int c = 0; c < 3; c++) cycle(4'($urandom), obs);
        #2;
        reset = 1'b1;
        #1;
        fv = pk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0) | {4'b1001, 12'h000};
        obs = {RegSrc, ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite};
        n_chk++;
        if (obs !== fv) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, fv);
        end
        @(posedge clk); #1;
        obs = {RegSrc, ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite};
        n_chk++;
        if (obs !== fv) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %h expected %h", obs, fv);
        end
        reset = 1'b0;
        mf = 4'b0000;
        q = '{mk(4'h0, 2'b10, 6'b0, 4'h0), mk(4'h1, 2'b10, 6'b0, 4'h0), ldr};
        foreach (q[k]) begin
            model(q[k], 4'h0);
            Instr = q[k];
            for (int c = 0; c < n_cyc; c++) begin
                cycle(4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL reset_after cyc%0d ins=%h: got %h expected %h", c, q[k], obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    task automatic test_random();
        logic [19:0] ins;
        logic [3:0]  af, cmd;
        for (int k = 0; k < 300; k++) begin
            ins = 20'($urandom);
            if ($urandom_range(1, 0) == 1) ins[19:16] = 4'hE;
            cmd = ins[12:9];
            if (ins[15:14] == 2'b00 && !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}))
                ins[8] = 1'b0;
            af = 4'($urandom);
            model(ins, af);
            Instr = ins;
            for (int c = 0; c < n_cyc; c++) begin
                cycle((c == exec_idx) ? af : 4'($urandom), obs);
                n_chk++;
                if ((obs & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                    n_fail++;
                    $display("FAIL random#%0d cyc%0d ins=%h: got %h expected %h", k, c, ins, obs & exp_m[c], exp_v[c] & exp_m[c]);
                end
            end
            mf = mf_after;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mem();
        test_branch();
        test_cmp();
        test_pc_dest();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
